// File: rtl/rca_share_seq.sv
// Two-requester front end that time-shares one 4-bit ripple-carry slice.
// A WIDTH-bit add takes WIDTH/4 cycles; the result returns on one valid/ready port.
module rca_share_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned KW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NIB - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d, cout_q, cout_d, id_q, id_d, last_q, last_d;
   logic [3:0]       nib_a, nib_b;
   logic [4:0]       add;
   logic             grant0, grant1;

   function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                          input logic ci);
      logic       c;
      logic [3:0] s;
      c = ci;
      for (int i = 0; i < 4; i++) begin
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, s};
   endfunction

   // Nibble k sits at bit offset 4*k, i.e. {k, 2'b00}.
   assign nib_a = 4'(a_q >> {k_q, 2'b00});
   assign nib_b = 4'(b_q >> {k_q, 2'b00});
   assign add   = ripple4(nib_a, nib_b, carry_q);

   // Round-robin: on a tie, the requester not served last wins.
   assign grant0 = req0_valid && (!req1_valid || last_q);
   assign grant1 = req1_valid && (!req0_valid || !last_q);

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      k_d        = k_q;
      carry_d    = carry_q;
      cout_d     = cout_q;
      id_d       = id_q;
      last_d     = last_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         StIdle: begin
            req0_ready = grant0 && !rst;
            req1_ready = grant1 && !rst;
            if (grant0 || grant1) begin
               a_d     = grant1 ? req1_a : req0_a;
               b_d     = grant1 ? req1_b : req0_b;
               carry_d = grant1 ? req1_cin : req0_cin;
               id_d    = grant1;
               last_d  = grant1;
               k_d     = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d   = (sum_q & ~(WIDTH'(4'hf) << {k_q, 2'b00}))
                    | (WIDTH'(add[3:0]) << {k_q, 2'b00});
            carry_d = add[4];
            k_d     = k_q + KW'(1);
            if (k_q == KLAST) begin
               cout_d  = add[4];
               state_d = StDone;
            end
         end
         StDone: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   assign rsp_valid = (state_q == StDone);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_id    = id_q;

endmodule

// File: tb/tb_rca_share_seq.sv
// Directed bench for rca_share_seq: a WIDTH=16 instance for arbitration, hold and
// reset behaviour, and a WIDTH=4 instance for the single-nibble case.
module tb_rca_share_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
   logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_sum;
   logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;

   logic        w4_req0_valid, w4_req0_ready, w4_req0_cin, w4_req1_valid, w4_req1_ready;
   logic        w4_req1_cin, w4_rsp_valid, w4_rsp_ready, w4_rsp_cout, w4_rsp_id;
   logic [3:0]  w4_req0_a, w4_req0_b, w4_req1_a, w4_req1_b, w4_rsp_sum;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rca_share_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_cin(req1_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .rsp_id(rsp_id)
   );

   rca_share_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(w4_req0_valid), .req0_ready(w4_req0_ready), .req0_a(w4_req0_a),
      .req0_b(w4_req0_b), .req0_cin(w4_req0_cin),
      .req1_valid(w4_req1_valid), .req1_ready(w4_req1_ready), .req1_a(w4_req1_a),
      .req1_b(w4_req1_b), .req1_cin(w4_req1_cin),
      .rsp_valid(w4_rsp_valid), .rsp_ready(w4_rsp_ready), .rsp_sum(w4_rsp_sum),
      .rsp_cout(w4_rsp_cout), .rsp_id(w4_rsp_id)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts edges until rsp_valid; bounded so a dead DUT shows up as a bad latency.
   task automatic wait_rsp16(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic pulse_rsp_ready16();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rsp_drop", rsp_valid, 0);
      rsp_ready = 1'b0;
   endtask

   task automatic do_op16(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] esum, input logic ecout);
      int lat;
      rsp_ready = 1'b0;
      if (id) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
      end
      #1;
      check("op_ready", id ? req1_ready : req0_ready, 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp16(lat);
      check("op_latency", lat, 4);
      check("op_sum", rsp_sum, esum);
      check("op_cout", rsp_cout, ecout);
      check("op_id", rsp_id, id);
      pulse_rsp_ready16();
   endtask

   task automatic do_op4(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [3:0] esum, input logic ecout);
      if (id) begin
         w4_req1_valid = 1'b1; w4_req1_a = a; w4_req1_b = b; w4_req1_cin = cin;
      end else begin
         w4_req0_valid = 1'b1; w4_req0_a = a; w4_req0_b = b; w4_req0_cin = cin;
      end
      #1;
      check("w4_ready", id ? w4_req1_ready : w4_req0_ready, 1);
      @(posedge clk);
      #1;
      w4_req0_valid = 1'b0;
      w4_req1_valid = 1'b0;
      check("w4_run_valid", w4_rsp_valid, 0);
      @(posedge clk);
      #1;
      check("w4_valid", w4_rsp_valid, 1);
      check("w4_sum", w4_rsp_sum, esum);
      check("w4_cout", w4_rsp_cout, ecout);
      check("w4_id", w4_rsp_id, id);
      w4_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("w4_drop", w4_rsp_valid, 0);
      w4_rsp_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, nacc, nrsp, n0, n1, last_cyc, gid;
      logic both_seen;

      rst = 1'b1;
      req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      rsp_ready = 1'b0;
      w4_req0_valid = 1'b0; w4_req0_a = '0; w4_req0_b = '0; w4_req0_cin = 1'b0;
      w4_req1_valid = 1'b0; w4_req1_a = '0; w4_req1_b = '0; w4_req1_cin = 1'b0;
      w4_rsp_ready = 1'b0;
      #1;
      check("rst_valid", rsp_valid, 0);
      check("rst_sum", rsp_sum, 0);
      check("rst_cout", rsp_cout, 0);
      check("rst_id", rsp_id, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      do_op16(1'b0, 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1);
      do_op16(1'b1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
      do_op16(1'b0, 16'h0fff, 16'h0001, 1'b0, 16'h1000, 1'b0);

      // Sustained contention from reset: strict alternation, 6-cycle issue period.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req0_a = 16'h0100; req0_b = 16'h0011; req0_cin = 1'b0;
      req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready = 1'b1;
      nacc = 0; nrsp = 0; n0 = 0; n1 = 0; last_cyc = 0; both_seen = 1'b0;
      for (int cyc = 0; cyc < 200 && nacc < 8; cyc++) begin
         #1;
         if (req0_ready && req1_ready) both_seen = 1'b1;
         if (rsp_valid) nrsp++;
         if (req0_ready || req1_ready) begin
            gid = req1_ready ? 1 : 0;
            check("rr_id", gid, nacc % 2);
            if (nacc > 0) check("rr_period", cyc - last_cyc, 6);
            last_cyc = cyc;
            nacc++;
            if (gid == 0) n0++;
            else n1++;
         end
         @(posedge clk);
         #1;
         if (n0 == 4) req0_valid = 1'b0;
         if (n1 == 4) req1_valid = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid) begin
            nrsp++;
            check("rr_last_sum", rsp_sum, 16'h0000);
            check("rr_last_id", rsp_id, 1);
         end
         @(posedge clk);
         #1;
      end
      check("rr_accepts", nacc, 8);
      check("rr_both", both_seen, 0);
      check("rr_rsps", nrsp, 8);
      rsp_ready = 1'b0;

      // Back-pressure: result held while a new request waits.
      req0_a = 16'h00f0; req0_b = 16'h0f10; req0_cin = 1'b1; req0_valid = 1'b1;
      #1;
      check("hold_acc", req0_ready, 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      wait_rsp16(lat);
      check("hold_latency", lat, 4);
      req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0; req0_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("hold_valid", rsp_valid, 1);
         check("hold_sum", rsp_sum, 16'h1001);
         check("hold_cout", rsp_cout, 0);
         check("hold_id", rsp_id, 0);
         check("hold_ready0", req0_ready, 0);
      end
      rsp_ready = 1'b1;
      #1;
      check("hold_nocomb", req0_ready, 0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("hold_idle_valid", rsp_valid, 0);
      check("hold_idle_ready", req0_ready, 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      wait_rsp16(lat);
      check("hold2_latency", lat, 4);
      check("hold2_sum", rsp_sum, 16'h0003);
      check("hold2_id", rsp_id, 0);
      pulse_rsp_ready16();

      // Reset two cycles into RUN abandons the add and restores the pointer.
      req0_a = 16'hffff; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
      #1;
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b1; req0_valid = 1'b1;
      req1_a = 16'h0005; req1_b = 16'h0005; req1_cin = 1'b0; req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_sum", rsp_sum, 0);
      check("mid_rst_cout", rsp_cout, 0);
      check("mid_rst_id", rsp_id, 0);
      check("mid_rst_ready0", req0_ready, 0);
      check("mid_rst_ready1", req1_ready, 0);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("mid_rst_hold", {rsp_valid, req0_ready, req1_ready}, 0);
      end
      rst = 1'b0;
      #1;
      check("post_rst_ready0", req0_ready, 1);
      check("post_rst_ready1", req1_ready, 0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp16(lat);
      check("post_rst_latency", lat, 4);
      check("post_rst_sum", rsp_sum, 16'h0004);
      check("post_rst_cout", rsp_cout, 0);
      check("post_rst_id", rsp_id, 0);
      pulse_rsp_ready16();

      do_op4(1'b0, 4'h9, 4'h8, 1'b0, 4'h1, 1'b1);
      do_op4(1'b1, 4'hf, 4'hf, 1'b1, 4'hf, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
